// File: rtl/exec_pkg.sv
// Shared encodings for the ALU execution controller: datapath width,
// ALU operations, B-operand shift modes and controller states.
package exec_pkg;

    localparam int W = 16;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_AND  = 2'b10,
        OP_NOTB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4,
        S_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/alu16.sv
// Combinational B-operand shifter, 16-bit ALU and {V,N,Z} flag generation.
module alu16
    import exec_pkg::*;
(
    input  op_e           op,
    input  shift_e        shift,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic [W-1:0]  result,
    output logic [2:0]    flags
);

    logic [W-1:0] bsh;
    logic         ovf;

    always_comb begin
        bsh = b;
        case (shift)
            SH_NONE: bsh = b;
            SH_LSL1: bsh = {b[W-2:0], 1'b0};
            SH_LSR1: bsh = {1'b0, b[W-1:1]};
            SH_ASR1: bsh = {b[W-1], b[W-1:1]};
            default: bsh = b;
        endcase
    end

    // Overflow: operands' signs (after negating B for SUB) agree but the result's differs.
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                result = a + bsh;
                ovf    = (a[W-1] == bsh[W-1]) && (result[W-1] != a[W-1]);
            end
            OP_SUB: begin
                result = a - bsh;
                ovf    = (a[W-1] != bsh[W-1]) && (result[W-1] != a[W-1]);
            end
            OP_AND: result = a & bsh;
            OP_NOTB: result = ~bsh;
            default: result = '0;
        endcase
    end

    assign flags = {ovf, result[W-1], (result == '0)};

endmodule

// File: rtl/alu_exec_ctrl.sv
// Sequencer that reads two register-file operands, runs one ALU op and writes
// the result back, one cycle per phase.
//
// state  | meaning
// IDLE   | waiting for start; captures op/shift/rn/rm/rd
// RD_A   | readnum=rn, load A from rf_data
// RD_B   | readnum=rm, load B from rf_data
// EXEC   | compute result, load C and status
// WB     | write C to register rd
// DONE   | one-cycle done pulse
module alu_exec_ctrl
    import exec_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [1:0]    shift,
    input  logic [2:0]    rn,
    input  logic [2:0]    rm,
    input  logic [2:0]    rd,
    input  logic [W-1:0]  rf_data,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic          write,
    output logic [W-1:0]  data_in,
    output logic          busy,
    output logic          done,
    output logic [2:0]    status
);

    state_e       state, state_nx;
    op_e          op_q;
    shift_e       shift_q;
    logic [2:0]   rn_q, rm_q, rd_q;
    logic [W-1:0] a_q, b_q, c_q;
    logic [2:0]   status_q;
    logic [W-1:0] alu_result;
    logic [2:0]   alu_flags;

    alu16 u_alu (
        .op     (op_q),
        .shift  (shift_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_RD_A;
            end
            S_RD_A: begin
                readnum  = rn_q;
                state_nx = S_RD_B;
            end
            S_RD_B: begin
                readnum  = rm_q;
                state_nx = S_EXEC;
            end
            S_EXEC: state_nx = S_WB;
            S_WB: begin
                write    = 1'b1;
                writenum = rd_q;
                state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_ADD;
            shift_q  <= SH_NONE;
            rn_q     <= 3'd0;
            rm_q     <= 3'd0;
            rd_q     <= 3'd0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op_e'(op);
                        shift_q <= shift_e'(shift);
                        rn_q    <= rn;
                        rm_q    <= rm;
                        rd_q    <= rd;
                    end
                end
                S_RD_A: a_q <= rf_data;
                S_RD_B: b_q <= rf_data;
                S_EXEC: begin
                    c_q      <= alu_result;
                    status_q <= alu_flags;
                end
                default: ;
            endcase
        end
    end

    assign data_in = c_q;
    assign status  = status_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed and randomized bench for alu_exec_ctrl with a behavioural register
// file and an arithmetic reference model of the shift/ALU/flag rules.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [1:0]  shift = 2'd0;
    logic [2:0]  rn = 3'd0, rm = 3'd0, rd = 3'd0;
    logic [15:0] rf_data;
    logic [2:0]  readnum, writenum;
    logic        write, busy, done;
    logic [15:0] data_in;
    logic [2:0]  status;

    logic [15:0] rf [8];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          last_flags = 0;

    assign rf_data = rf[readnum];

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .shift    (shift),
        .rn       (rn),
        .rm       (rm),
        .rd       (rd),
        .rf_data  (rf_data),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .status   (status)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed16(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    // Reference: shift and op rules evaluated with plain integer arithmetic.
    function automatic void model(input int opc, input int sh, input int a, input int b,
                                  output int res, output int flags);
        int bs, full, v;
        case (sh)
            0:       bs = b;
            1:       bs = (b * 2) % 65536;
            2:       bs = b / 2;
            default: bs = b / 2 + ((b >= 32768) ? 32768 : 0);
        endcase
        v = 0;
        case (opc)
            0: begin
                full = to_signed16(a) + to_signed16(bs);
                res  = (a + bs) % 65536;
                v    = (full > 32767 || full < -32768) ? 1 : 0;
            end
            1: begin
                full = to_signed16(a) - to_signed16(bs);
                res  = (a - bs + 65536) % 65536;
                v    = (full > 32767 || full < -32768) ? 1 : 0;
            end
            2:       res = a & bs;
            default: res = 65535 - bs;
        endcase
        flags = v * 4 + ((res >= 32768) ? 2 : 0) + ((res == 0) ? 1 : 0);
    endfunction

    task automatic launch(input int o, input int s, input int a_i, input int m_i, input int d_i,
                          input string tag);
        @(negedge clk);
        chk({tag, ":idle"}, {busy, done, write, readnum, writenum}, 9'b0);
        chk({tag, ":status_hold"}, 32'(status), 32'(last_flags));
        op = 2'(o); shift = 2'(s); rn = 3'(a_i); rm = 3'(m_i); rd = 3'(d_i);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom); shift = 2'($urandom);
        rn = 3'($urandom); rm = 3'($urandom); rd = 3'($urandom);
    endtask

    task automatic run_op(input int o, input int s, input int a_i, input int m_i, input int d_i,
                          input bit pulse_mid, input string tag);
        int exp_res, exp_fl, writes;
        model(o, s, int'(rf[a_i]), int'(rf[m_i]), exp_res, exp_fl);
        launch(o, s, a_i, m_i, d_i, tag);
        writes = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (write) writes++;
            case (k)
                1: chk({tag, ":rd_a"}, {busy, done, write, readnum, writenum},
                       {1'b1, 1'b0, 1'b0, 3'(a_i), 3'd0});
                2: begin
                    chk({tag, ":rd_b"}, {busy, done, write, readnum, writenum},
                        {1'b1, 1'b0, 1'b0, 3'(m_i), 3'd0});
                    if (pulse_mid) start = 1'b1;
                end
                3: chk({tag, ":exec"}, {busy, done, write, readnum, writenum},
                       {1'b1, 1'b0, 1'b0, 3'd0, 3'd0});
                4: begin
                    start = 1'b0;
                    chk({tag, ":wb"}, {busy, done, write, readnum, writenum},
                        {1'b1, 1'b0, 1'b1, 3'd0, 3'(d_i)});
                    chk({tag, ":wb_data"}, 32'(data_in), 32'(exp_res));
                end
                default: begin
                    chk({tag, ":done"}, {busy, done, write, readnum, writenum},
                        {1'b1, 1'b1, 1'b0, 3'd0, 3'd0});
                    chk({tag, ":status"}, 32'(status), 32'(exp_fl));
                end
            endcase
        end
        chk({tag, ":writes"}, 32'(writes), 32'd1);
        rf[d_i] = 16'(exp_res);
        last_flags = exp_fl;
    endtask

    task automatic reset_mid(input string tag);
        int writes;
        launch(0, 0, 1, 2, 3, tag);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk({tag, ":exec"}, {busy, done, write, readnum, writenum}, {1'b1, 8'b0});
        rst_n = 1'b0;
        #1;
        chk({tag, ":rst_ctl"}, {busy, done, write, readnum, writenum}, 9'b0);
        chk({tag, ":rst_data"}, 32'(data_in), 32'd0);
        chk({tag, ":rst_status"}, 32'(status), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_flags = 0;
        writes = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (write) writes++;
        end
        chk({tag, ":post_ctl"}, {busy, done, write, readnum, writenum}, 9'b0);
        chk({tag, ":no_write"}, 32'(writes), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
        #1;
        chk("reset:ctl", {busy, done, write, readnum, writenum}, 9'b0);
        chk("reset:data", 32'(data_in), 32'd0);
        chk("reset:status", 32'(status), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        rf[1] = 16'h0003; rf[2] = 16'h0005;
        run_op(0, 0, 1, 2, 3, 1'b0, "add_basic");
        chk("add_basic:r3", 32'(rf[3]), 32'h0008);

        rf[1] = 16'h7FFF; rf[2] = 16'h0001;
        run_op(0, 0, 1, 2, 6, 1'b0, "add_ovf");

        rf[4] = 16'h1234; rf[5] = 16'h1234;
        run_op(1, 0, 4, 5, 4, 1'b0, "sub_hazard");

        rf[2] = 16'h8004;
        run_op(3, 3, 1, 2, 7, 1'b0, "notb_asr");
        chk("notb_asr:r7", 32'(rf[7]), 32'h3FFD);

        run_op(2, 1, 3, 7, 0, 1'b1, "start_pulse");

        reset_mid("rst_exec");
        run_op(0, 2, 3, 6, 5, 1'b0, "after_rst");

        for (int t = 0; t < 40; t++) begin
            int ro, rs, ra, rb, rdst;
            ro = $urandom_range(0, 3);
            rs = $urandom_range(0, 3);
            ra = $urandom_range(0, 7);
            rb = $urandom_range(0, 7);
            rdst = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 7);
            if ($urandom_range(0, 4) == 0) rf[ra] = 16'h8000;
            run_op(ro, rs, ra, rb, rdst, 1'($urandom_range(0, 1)), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  request one operation; sampled only in IDLE.
REQ-004 SHALL have port: op  input  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 NOT-B.
REQ-005 SHALL have port: shift  input  2  B-operand shift: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1 (sign fill).
REQ-006 SHALL have ports: rn, rm, rd  input  3 each  source A, source B, destination register index.
REQ-007 SHALL have port: rf_data  input  16  combinational read data from the 8x16 register file.
REQ-008 SHALL have port: readnum  output  3  register file read index.
REQ-009 SHALL have ports: writenum  output  3, write  output  1, data_in  output  16  register file write port.
REQ-010 SHALL have ports: busy  output  1 (high in any state but IDLE), done  output  1 (one-cycle completion pulse).
REQ-011 SHALL have port: status  output  3  {V,N,Z} flags from the last completed EXEC.

Function
REQ-012 SHALL implement FSM IDLE -> RD_A -> RD_B -> EXEC -> WB -> DONE -> IDLE, one cycle per non-IDLE state.
REQ-013 SHALL, on the edge where start=1 in IDLE, capture op, shift, rn, rm, rd into internal registers and enter RD_A.
REQ-014 SHALL ignore start in every state except IDLE; input changes after capture have no effect.
REQ-015 SHALL drive readnum=rn in RD_A, readnum=rm in RD_B, readnum=0 otherwise.
REQ-016 SHALL load register A from rf_data at the end of RD_A and register B at the end of RD_B.
REQ-017 SHALL in EXEC compute Bsh = shift(B), result = op(A,Bsh) mod 2^16, and load C and status at the end of EXEC.
REQ-018 SHALL set Z when result==0, N = result[15], V = signed overflow for ADD/SUB, V=0 for AND/NOT-B.
REQ-019 SHALL in WB drive write=1, writenum=rd, data_in=C; write=0 in all other states.
REQ-020 SHALL drive writenum=0 outside WB and data_in=C at all times.
REQ-021 SHALL assert done for exactly the DONE cycle; start-to-done latency is 5 cycles after the capturing edge.
REQ-022 SHALL allow back-to-back operations: start high in the IDLE cycle following DONE is accepted.
REQ-023 SHALL handle rd==rn or rd==rm correctly: both reads complete before WB.
REQ-024 SHALL hold status unchanged outside EXEC.

Reset
REQ-025 SHALL, on rst_n low, immediately enter IDLE and clear A, B, C, status, captured fields; write=0, done=0, busy=0, readnum=0, writenum=0, data_in=0.
REQ-026 SHALL abandon any operation in progress on reset mid-operation; no write is issued after rst_n deasserts.
REQ-027 SHALL resume normal operation on the first rising edge with rst_n high.

Structure
REQ-028 SHALL place op encodings, shift encodings, FSM state enum and width constant (16) in shared package exec_pkg.
REQ-029 SHALL implement shifter plus ALU plus flag logic as one combinational sub-module alu16; FSM and registers stay in alu_exec_ctrl.

Verification
REQ-030 SHALL cover: R1=0x0003, R2=0x0005, ADD, no shift, rd=R3 -> write of 0x0008 to R3 in WB, status=000, done 5 cycles after start.
REQ-031 SHALL cover: R1=0x7FFF, R2=0x0001, ADD -> 0x8000, status V=1,N=1,Z=0.
REQ-032 SHALL cover: R4=0x1234, R5=0x1234, SUB, rd=R4 -> 0x0000 written to R4, Z=1; rd==rn hazard correct.
REQ-033 SHALL cover: R2=0x8004, NOT-B with ASR1 -> Bsh=0xC002, result 0x3FFD.
REQ-034 SHALL cover: start pulsed during RD_B and EXEC -> ignored, exactly one write and one done.
REQ-035 SHALL cover: rst_n low during EXEC -> write never asserts, all outputs zero, next start completes normally.
